// File: rtl/piso_tx_ctrl_pkg.sv
// Shared definitions for the PISO transmit controller: FSM state encodings and
// the bit-counter width helper. Optional parity macro: PISO_TX_PARITY_EN.
package piso_tx_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_PAR   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_PAR   = ST_PAR,
    S_DONE  = ST_DONE
  } tx_state_e;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tx_bit_counter.sv
// Counts accepted serial beats within a frame; flags the final data bit.
// Saturates at N-1 so it never wraps inside a frame.
module tx_bit_counter
  import piso_tx_ctrl_pkg::*;
#(
  parameter int N = 4,
  localparam int CW = cnt_width(N)
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          last
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && !last) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == CW'(N - 1));

endmodule

// File: rtl/piso_tx_ctrl.sv
// Parallel-in/serial-out transmit controller: accepts an N-bit word, shifts it out
// MSB-first under ser_ready backpressure, then pulses done. Macro PISO_TX_PARITY_EN
// appends an even-parity beat after the data bits.
module piso_tx_ctrl
  import piso_tx_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         ser_out,
  output logic         ser_valid,
  input  logic         ser_ready,
  output logic         busy,
  output logic         done
);

  localparam int CW = cnt_width(N);

  tx_state_e     state_q;
  logic [N-1:0]  sreg_q;
  logic          accept;
  logic          shift;
  logic          last;
  // Bit index is only needed inside the counter; kept as a port for observability.
  logic [CW-1:0] cnt_unused;
`ifdef PISO_TX_PARITY_EN
  logic          par_q;
`endif

  assign accept = in_valid & in_ready;
  assign shift  = (state_q == S_SHIFT) & ser_ready;

  tx_bit_counter #(.N(N)) u_cnt (
    .clk  (clk),
    .clr_n(clr_n),
    .clear(accept),
    .inc  (shift),
    .cnt  (cnt_unused),
    .last (last)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
`ifdef PISO_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            sreg_q  <= in_data;
`ifdef PISO_TX_PARITY_EN
            par_q   <= ^in_data;
`endif
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (ser_ready) begin
            sreg_q <= {sreg_q[N-2:0], 1'b0};
            if (last) begin
`ifdef PISO_TX_PARITY_EN
              state_q <= S_PAR;
`else
              state_q <= S_DONE;
`endif
            end
          end
        end
`ifdef PISO_TX_PARITY_EN
        S_PAR: begin
          if (ser_ready) begin
            state_q <= S_DONE;
          end
        end
`endif
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // in_ready is gated by clr_n so no word can be offered as accepted during reset.
  assign in_ready  = clr_n & (state_q == S_IDLE);
  assign ser_valid = (state_q == S_SHIFT) | (state_q == S_PAR);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
`ifdef PISO_TX_PARITY_EN
  assign ser_out   = (state_q == S_PAR) ? par_q : sreg_q[N-1];
`else
  assign ser_out   = sreg_q[N-1];
`endif

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Directed bench for piso_tx_ctrl (N=4 and N=8 instances); expected serial beats
// include the parity beat when PISO_TX_PARITY_EN is defined.
module tb_piso_tx_ctrl;

`ifdef PISO_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB4 = 4 + PB;
  localparam int NB8 = 8 + PB;

  logic       clk;
  logic       clr_n;
  logic [3:0] in_data;
  logic       in_valid, in_ready, ser_out, ser_valid, ser_ready, busy, done;
  logic [7:0] in_data8;
  logic       in_valid8, in_ready8, ser_out8, ser_valid8, ser_ready8, busy8, done8;

  int n_cmp;
  int n_err;

  piso_tx_ctrl #(.N(4)) dut (
    .clk(clk), .clr_n(clr_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .ser_ready(ser_ready), .busy(busy), .done(done)
  );

  piso_tx_ctrl #(.N(8)) dut8 (
    .clk(clk), .clr_n(clr_n), .in_data(in_data8), .in_valid(in_valid8),
    .in_ready(in_ready8), .ser_out(ser_out8), .ser_valid(ser_valid8),
    .ser_ready(ser_ready8), .busy(busy8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat k of a frame: data MSB-first, then the even-parity bit.
  function automatic logic exp_bit(input logic [7:0] w, input int n, input int k);
    if (k < n) return w[n-1-k];
    return ^w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0; in_data = 4'h0; in_valid = 1'b0; ser_ready = 1'b0;
    in_data8 = 8'h00; in_valid8 = 1'b0; ser_ready8 = 1'b0;
    repeat (2) tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (ser_valid !== 1'b0) begin n_err++; $display("FAIL rst_ser_valid: got %b want 0", ser_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (in_ready8 !== 1'b0) begin n_err++; $display("FAIL rst_in_ready8: got %b want 0", in_ready8); end
    clr_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_rel_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (ser_out !== 1'b0) begin n_err++; $display("FAIL rst_ser_out: got %b want 0", ser_out); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_rel_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    logic e;
    in_data = 4'b1011; in_valid = 1'b1; ser_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < NB4; k++) begin
      e = exp_bit(8'h0B, 4, k);
      n_cmp++; if (ser_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid%0d: got %b want 1", k, ser_valid); end
      n_cmp++; if (ser_out !== e) begin n_err++; $display("FAIL basic_bit%0d: got %b want %b", k, ser_out, e); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy%0d: got %b want 1", k, busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_early_done%0d: got %b want 0", k, done); end
      tick();
    end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b want 1", done); end
    n_cmp++; if (ser_valid !== 1'b0) begin n_err++; $display("FAIL basic_done_valid: got %b want 0", ser_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_done_ready: got %b want 0", in_ready); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_done_width: got %b want 0", done); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_idle_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_backpressure();
    logic e;
    int dcount;
    dcount = 0;
    in_data = 4'b1011; in_valid = 1'b1; ser_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (ser_out !== 1'b1) begin n_err++; $display("FAIL bp_bit0: got %b want 1", ser_out); end
    tick();
    ser_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      n_cmp++; if (ser_out !== 1'b0) begin n_err++; $display("FAIL bp_hold_bit%0d: got %b want 0", s, ser_out); end
      n_cmp++; if (ser_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid%0d: got %b want 1", s, ser_valid); end
      if (done === 1'b1) dcount++;
      tick();
    end
    ser_ready = 1'b1;
    for (int k = 1; k < NB4; k++) begin
      e = exp_bit(8'h0B, 4, k);
      n_cmp++; if (ser_out !== e) begin n_err++; $display("FAIL bp_bit%0d: got %b want %b", k, ser_out, e); end
      n_cmp++; if (ser_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid%0d: got %b want 1", k, ser_valid); end
      if (done === 1'b1) dcount++;
      tick();
    end
    for (int s = 0; s < 3; s++) begin
      if (done === 1'b1) dcount++;
      tick();
    end
    n_cmp++; if (dcount !== 1) begin n_err++; $display("FAIL bp_done_count: got %0d want 1", dcount); end
  endtask

  task automatic test_back_to_back();
    logic e;
    int dcount;
    dcount = 0;
    in_data = 4'hF; in_valid = 1'b1; ser_ready = 1'b1;
    tick();
    in_data = 4'h0;
    for (int k = 0; k < NB4; k++) begin
      e = exp_bit(8'h0F, 4, k);
      n_cmp++; if (ser_out !== e) begin n_err++; $display("FAIL b2b_first_bit%0d: got %b want %b", k, ser_out, e); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_first_ready%0d: got %b want 0", k, in_ready); end
      if (done === 1'b1) dcount++;
      tick();
    end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_done_ready: got %b want 0", in_ready); end
    if (done === 1'b1) dcount++;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_idle_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < NB4; k++) begin
      e = exp_bit(8'h00, 4, k);
      n_cmp++; if (ser_out !== e) begin n_err++; $display("FAIL b2b_second_bit%0d: got %b want %b", k, ser_out, e); end
      n_cmp++; if (ser_valid !== 1'b1) begin n_err++; $display("FAIL b2b_second_valid%0d: got %b want 1", k, ser_valid); end
      if (done === 1'b1) dcount++;
      tick();
    end
    for (int s = 0; s < 3; s++) begin
      if (done === 1'b1) dcount++;
      tick();
    end
    n_cmp++; if (dcount !== 2) begin n_err++; $display("FAIL b2b_done_count: got %0d want 2", dcount); end
  endtask

  task automatic test_abort();
    logic e;
    int dcount;
    dcount = 0;
    in_data = 4'b1011; in_valid = 1'b1; ser_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (ser_out !== 1'b1) begin n_err++; $display("FAIL abort_bit0: got %b want 1", ser_out); end
    tick();
    n_cmp++; if (ser_out !== 1'b0) begin n_err++; $display("FAIL abort_bit1: got %b want 0", ser_out); end
    tick();
    clr_n = 1'b0;
    #1;
    n_cmp++; if (ser_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid: got %b want 0", ser_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL abort_ready: got %b want 0", in_ready); end
    tick();
    clr_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      if (done === 1'b1) dcount++;
      tick();
    end
    n_cmp++; if (dcount !== 0) begin n_err++; $display("FAIL abort_done_count: got %0d want 0", dcount); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_idle_ready: got %b want 1", in_ready); end
    in_data = 4'b0110; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < NB4; k++) begin
      e = exp_bit(8'h06, 4, k);
      n_cmp++; if (ser_out !== e) begin n_err++; $display("FAIL abort_next_bit%0d: got %b want %b", k, ser_out, e); end
      tick();
    end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL abort_next_done: got %b want 1", done); end
    tick();
  endtask

`ifdef PISO_TX_PARITY_EN
  task automatic test_parity();
    logic [4:0] exp_a;
    logic [4:0] exp_b;
    exp_a = 5'b01111;
    exp_b = 5'b00110;
    in_data = 4'b0111; in_valid = 1'b1; ser_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (ser_out !== exp_a[4-k]) begin n_err++; $display("FAIL par_a_bit%0d: got %b want %b", k, ser_out, exp_a[4-k]); end
      tick();
    end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL par_a_done: got %b want 1", done); end
    tick();
    in_data = 4'b0011; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (ser_out !== exp_b[4-k]) begin n_err++; $display("FAIL par_b_bit%0d: got %b want %b", k, ser_out, exp_b[4-k]); end
      tick();
    end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL par_b_done: got %b want 1", done); end
    tick();
  endtask
`endif

  task automatic test_wide();
    logic e;
    in_data8 = 8'hA5; in_valid8 = 1'b1; ser_ready8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    for (int k = 0; k < NB8; k++) begin
      e = exp_bit(8'hA5, 8, k);
      n_cmp++; if (ser_out8 !== e) begin n_err++; $display("FAIL wide_bit%0d: got %b want %b", k, ser_out8, e); end
      n_cmp++; if (done8 !== 1'b0) begin n_err++; $display("FAIL wide_early_done%0d: got %b want 0", k, done8); end
      tick();
    end
    n_cmp++; if (done8 !== 1'b1) begin n_err++; $display("FAIL wide_done: got %b want 1", done8); end
    tick();
    n_cmp++; if (in_ready8 !== 1'b1) begin n_err++; $display("FAIL wide_idle_ready: got %b want 1", in_ready8); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_abort();
`ifdef PISO_TX_PARITY_EN
    test_parity();
`endif
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
